log_capture_ctrl: RTL and testbench
===================================

LOG_CAPTURE_CTRL -- requirements
Module: log_capture_ctrl

Interface
REQ-001 Parameter ADDR_W, default 15, SHALL set the log RAM address width.
REQ-002 Parameter DEPTH, default 32768, SHALL equal 2**ADDR_W and set the log RAM depth in words.
REQ-003 clockdsp  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 soft_reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 arm  input  1  SHALL be a one-cycle pulse from the micro that starts a capture.
REQ-006 abort  input  1  SHALL be a one-cycle pulse from the micro that cancels a capture.
REQ-007 post_len  input  ADDR_W  SHALL give the post-trigger sample count, trigger sample included; sampled on arm.
REQ-008 sample_valid  input  1  SHALL qualify the current datapath sample for writing.
REQ-009 trig_in  input  1  SHALL be the hardware trigger level; a rising edge is a trigger event.
REQ-010 sw_trig  input  1  SHALL be a one-cycle software trigger pulse.
REQ-011 rd_idx  input  ADDR_W  SHALL give the chronological read index from the micro; 0 is the oldest sample.
REQ-012 we  output  1  SHALL be the RAM write enable.
REQ-013 waddr  output  ADDR_W  SHALL be the RAM write address.
REQ-014 rd_addr  output  ADDR_W  SHALL be the physical RAM read address for rd_idx.
REQ-015 trig_addr  output  ADDR_W  SHALL hold the address of the trigger sample.
REQ-016 start_addr  output  ADDR_W  SHALL hold the address of the oldest captured sample.
REQ-017 done  output  1  SHALL be high while the capture is complete.
REQ-018 busy  output  1  SHALL be high in FILL, ARMED and POST.
REQ-019 state  output  3  SHALL encode IDLE=0, FILL=1, ARMED=2, POST=3, DONE=4.

Function
REQ-020 we SHALL be combinational: sample_valid AND (state is FILL, ARMED or POST); waddr SHALL increment modulo DEPTH after each write.
REQ-021 post_len=0 SHALL be treated as 1; pre-trigger length pre = DEPTH - post_len(effective), latched on arm.
REQ-022 IDLE or DONE, arm=1 -> FILL; waddr, fill count and post count cleared; done cleared; post_len latched.
REQ-023 FILL SHALL write pre samples at addresses 0..pre-1, then enter ARMED on the cycle after the pre-th write.
REQ-024 Trigger events (trig_in rising edge vs its registered copy, or sw_trig) in FILL, POST, DONE or IDLE SHALL be ignored.
REQ-025 ARMED SHALL write circularly, wrapping DEPTH-1 -> 0.
REQ-026 A trigger event in ARMED SHALL set a pending flag, consumed by the first valid write on that cycle or later.
REQ-027 The consuming write's address SHALL load trig_addr, and that write SHALL count as post sample 1.
REQ-028 POST SHALL continue writing until post_len(effective) post samples are written, then enter DONE next cycle.
REQ-029 post_len(effective)=1 SHALL go ARMED -> DONE directly after the trigger write.
REQ-030 On entry to DONE, start_addr SHALL be trig_addr + post_len(effective) mod DEPTH, which equals waddr.
REQ-031 DONE SHALL hold done=1 and we=0 until arm, abort or reset.
REQ-032 abort in any state -> IDLE next cycle, done=0, pending trigger cleared; trig_addr and start_addr retained.
REQ-033 abort and arm in the same cycle -> abort wins.
REQ-034 arm during FILL, ARMED or POST SHALL be ignored.
REQ-035 rd_addr SHALL be registered: start_addr + rd_idx mod DEPTH, valid one cycle after rd_idx.

Reset
REQ-036 soft_reset=1 -> next state IDLE.
REQ-037 soft_reset=1 SHALL zero waddr, rd_addr, trig_addr, start_addr, counters, pending flag and the trig_in delay register.
REQ-038 Out of reset, done, busy and we SHALL be 0.
REQ-039 Reset asserted mid-capture SHALL override arm, abort and triggers.

Verification
All scenarios use DEPTH=16, ADDR_W=4, post_len=4, sample_valid=1 and arm at cycle 0 unless stated.
REQ-040 Baseline trigger: trig_in rises at cycle 20 -> writes addr 0..11 in cycles 1..12; trig_addr=3; writes 3..6; done=1 at cycle 24; start_addr=7.
REQ-041 Trigger during FILL: sw_trig at cycle 5 -> no state change, FILL continues; a later trigger at cycle 20 gives the REQ-040 result.
REQ-042 Zero post length: post_len=0, trigger at cycle 20 -> trig_addr=3; DONE at cycle 21; start_addr=4.
REQ-043 Gated samples: sample_valid alternating 1/0 with trigger on an invalid cycle -> waddr advances only on valid cycles; trig_addr equals the next valid write address.
REQ-044 Abort and reset: abort in POST -> IDLE, we=0, done=0 next cycle; arm+abort together -> IDLE; soft_reset in ARMED -> all outputs 0.
REQ-045 Readout: after REQ-040, rd_idx=10 -> rd_addr=1 one cycle later; rd_idx=0 -> rd_addr=7.

Source files
------------

// File: rtl/log_capture_ctrl.sv
// log_capture_ctrl: write-side controller for a circular capture RAM.
// It fills a pre-trigger window, then writes circularly until a trigger is
// seen, then captures a post-trigger window and freezes. The outputs give
// the trigger sample address, the oldest sample address and a registered
// chronological-to-physical read address translation for the micro.
//
// Control pulses: arm, abort and sw_trig are single-cycle strobes sampled on
// the rising edge of clockdsp. There is no back-pressure. A RAM write occurs
// in every cycle where we=1, at address waddr. sample_valid only qualifies
// that cycle's sample and is never stalled.
module log_capture_ctrl #(
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 32768
) (
    input  logic              clockdsp,
    input  logic              soft_reset,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] post_len,
    input  logic              sample_valid,
    input  logic              trig_in,
    input  logic              sw_trig,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr,
    output logic              done,
    output logic              busy,
    output logic [2:0]        state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Highest RAM address. DEPTH is 2**ADDR_W, so address arithmetic wraps
    // naturally in ADDR_W bits.
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    logic [2:0]        state_q, state_d;
    logic              trig_q, trig_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] post_len_q, post_len_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [ADDR_W-1:0] rd_addr_q;

    logic              capturing;
    logic              wr_en;
    logic              trig_event;
    logic              trig_hit;
    logic              arm_accept;
    logic              fill_last;
    logic              post_last;
    logic              post_is_one;
    logic [ADDR_W-1:0] pre_last;
    logic [ADDR_W-1:0] post_cnt_inc;
    logic [ADDR_W-1:0] post_len_eff;

    // Decode of the conditions shared by the FSM and the datapath.
    always_comb begin
        capturing    = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
        wr_en        = sample_valid && capturing;
        trig_event   = (trig_in && !trig_q) || sw_trig;
        // A zero post length is treated as one: the trigger sample alone.
        post_len_eff = (post_len == '0) ? ONE : post_len;
        post_is_one  = (post_len_q == ONE);
        // pre = DEPTH - post, so the last fill index is DEPTH-1-post.
        pre_last     = ADDR_MAX - post_len_q;
        post_cnt_inc = post_cnt_q + ONE;
        trig_hit     = (state_q == S_ARMED) && wr_en && (trig_event || pend_q);
        fill_last    = (state_q == S_FILL) && wr_en && (fill_cnt_q == pre_last);
        post_last    = (state_q == S_POST) && wr_en && (post_cnt_inc == post_len_q);
        arm_accept   = arm && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // State register; reset overrides every control input.
    always_ff @(posedge clockdsp) begin
        if (soft_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over arm and over any capture progress.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) state_d = S_FILL;
                end
                S_FILL: begin
                    if (fill_last) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (trig_hit) state_d = post_is_one ? S_DONE : S_POST;
                end
                S_POST: begin
                    if (post_last) state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from the current state.
    always_comb begin
        we    = wr_en;
        done  = (state_q == S_DONE);
        busy  = capturing;
        state = state_q;
    end

    // Datapath next values: write pointer, window counters, trigger capture.
    always_comb begin
        trig_d       = trig_in;
        pend_d       = pend_q;
        waddr_d      = waddr_q;
        fill_cnt_d   = fill_cnt_q;
        post_cnt_d   = post_cnt_q;
        post_len_d   = post_len_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;

        if (abort) begin
            // Trigger and start addresses of the last capture are kept.
            pend_d = 1'b0;
        end else if (arm_accept) begin
            waddr_d    = '0;
            fill_cnt_d = '0;
            post_cnt_d = '0;
            pend_d     = 1'b0;
            post_len_d = post_len_eff;
        end else begin
            if (wr_en) begin
                waddr_d = waddr_q + ONE;
            end

            case (state_q)
                S_FILL: begin
                    if (wr_en) fill_cnt_d = fill_cnt_q + ONE;
                end
                S_ARMED: begin
                    if (trig_hit) begin
                        // The consuming write is the trigger and post sample 1.
                        trig_addr_d = waddr_q;
                        post_cnt_d  = ONE;
                        pend_d      = 1'b0;
                        if (post_is_one) start_addr_d = waddr_q + ONE;
                    end else if (trig_event) begin
                        // Trigger on a gated cycle waits for the next write.
                        pend_d = 1'b1;
                    end
                end
                S_POST: begin
                    if (wr_en) begin
                        post_cnt_d = post_cnt_inc;
                        // Oldest sample is the one after the final write.
                        if (post_last) start_addr_d = waddr_q + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clockdsp) begin
        if (soft_reset) begin
            trig_q       <= 1'b0;
            pend_q       <= 1'b0;
            waddr_q      <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            post_len_q   <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
        end else begin
            trig_q       <= trig_d;
            pend_q       <= pend_d;
            waddr_q      <= waddr_d;
            fill_cnt_q   <= fill_cnt_d;
            post_cnt_q   <= post_cnt_d;
            post_len_q   <= post_len_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
        end
    end

    // Chronological index to physical address, one cycle of latency.
    always_ff @(posedge clockdsp) begin
        if (soft_reset) begin
            rd_addr_q <= '0;
        end else begin
            rd_addr_q <= start_addr_q + rd_idx;
        end
    end

    assign waddr      = waddr_q;
    assign rd_addr    = rd_addr_q;
    assign trig_addr  = trig_addr_q;
    assign start_addr = start_addr_q;

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Directed bench for log_capture_ctrl with a 16-word log RAM.
// Cycle n is the clock period in which the inputs for posedge n+1 are held;
// arm is driven in cycle 0, so the first write happens in cycle 1.
module tb_log_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clockdsp = 1'b0;
    logic              soft_reset;
    logic              arm;
    logic              abort;
    logic [ADDR_W-1:0] post_len;
    logic              sample_valid;
    logic              trig_in;
    logic              sw_trig;
    logic [ADDR_W-1:0] rd_idx;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] start_addr;
    logic              done;
    logic              busy;
    logic [2:0]        state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    log_capture_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clockdsp     (clockdsp),
        .soft_reset   (soft_reset),
        .arm          (arm),
        .abort        (abort),
        .post_len     (post_len),
        .sample_valid (sample_valid),
        .trig_in      (trig_in),
        .sw_trig      (sw_trig),
        .rd_idx       (rd_idx),
        .we           (we),
        .waddr        (waddr),
        .rd_addr      (rd_addr),
        .trig_addr    (trig_addr),
        .start_addr   (start_addr),
        .done         (done),
        .busy         (busy),
        .state        (state)
    );

    // Clock and reset
    always #5 clockdsp = ~clockdsp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clockdsp);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        soft_reset   = 1'b1;
        arm          = 1'b0;
        abort        = 1'b0;
        post_len     = '0;
        sample_valid = 1'b1;
        trig_in      = 1'b0;
        sw_trig      = 1'b0;
        rd_idx       = '0;
        tick();
        tick();
        soft_reset = 1'b0;
    endtask

    // Drive arm in cycle 0 and step into cycle 1.
    task automatic start(input logic [ADDR_W-1:0] pl);
        post_len = pl;
        arm      = 1'b1;
        cyc      = 0;
        tick();
        arm = 1'b0;
    endtask

    // Baseline capture up to cycle 21 (first POST cycle). When sw_at >= 0 a
    // software trigger and a stray arm are pulsed in FILL at that cycle.
    task automatic run_to_post(input int sw_at);
        start(4'd4);
        chk("fill_entry_state", state, 1);
        chk("fill_entry_waddr", waddr, 0);
        chk("fill_entry_we", we, 1);
        if (sw_at >= 0) begin
            go_to(sw_at);
            sw_trig = 1'b1;
            arm     = 1'b1;
            tick();
            sw_trig = 1'b0;
            arm     = 1'b0;
            chk("fill_ign_state", state, 1);
            chk("fill_ign_waddr", waddr, sw_at);
        end
        go_to(12);
        chk("fill_last_waddr", waddr, 11);
        chk("fill_last_state", state, 1);
        tick();
        chk("armed_state", state, 2);
        chk("armed_waddr", waddr, 12);
        go_to(20);
        trig_in = 1'b1;
        #1;
        chk("trig_cycle_waddr", waddr, 3);
        chk("trig_cycle_we", we, 1);
        tick();
        chk("post_state", state, 3);
        chk("post_trig_addr", trig_addr, 3);
        chk("post_waddr", waddr, 4);
    endtask

    task automatic check_baseline_done();
        go_to(23);
        chk("pre_done_state", state, 3);
        tick();
        chk("done_state", state, 4);
        chk("done_flag", done, 1);
        chk("done_we", we, 0);
        chk("done_busy", busy, 0);
        chk("done_start_addr", start_addr, 7);
        chk("done_waddr", waddr, 7);
        chk("done_trig_addr", trig_addr, 3);
    endtask

    initial begin
        do_reset();
        chk("rst_state", state, 0);
        chk("rst_we", we, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_waddr", waddr, 0);

        // Baseline capture and readout
        run_to_post(-1);
        check_baseline_done();
        rd_idx = 4'd10;
        tick();
        chk("rd_idx10", rd_addr, 1);
        rd_idx = 4'd0;
        tick();
        chk("rd_idx0", rd_addr, 7);
        rd_idx = 4'd15;
        tick();
        chk("rd_idx15", rd_addr, 6);

        // Trigger and arm ignored during FILL
        do_reset();
        run_to_post(5);
        check_baseline_done();

        // Zero post length
        do_reset();
        start(4'd0);
        go_to(20);
        trig_in = 1'b1;
        tick();
        chk("zpost_state", state, 4);
        chk("zpost_trig_addr", trig_addr, 3);
        chk("zpost_start_addr", start_addr, 4);
        chk("zpost_done", done, 1);

        // Gated samples with the trigger on an invalid cycle
        do_reset();
        start(4'd4);
        go_to(13);
        chk("gate_armed", state, 2);
        while (cyc < 24) begin
            sample_valid = cyc[0];
            sw_trig      = (cyc == 16);
            #1;
            if (cyc == 16) begin
                chk("gate_trig_waddr", waddr, 14);
                chk("gate_trig_we", we, 0);
            end
            if (cyc == 17) chk("gate_pend_state", state, 2);
            if (cyc == 18) begin
                chk("gate_post_state", state, 3);
                chk("gate_trig_addr", trig_addr, 14);
            end
            if (cyc == 20) chk("gate_mid_waddr", waddr, 0);
            tick();
        end
        sw_trig      = 1'b0;
        sample_valid = 1'b1;
        chk("gate_done_state", state, 4);
        chk("gate_start_addr", start_addr, 2);
        chk("gate_waddr", waddr, 2);

        // Abort in POST, arm+abort, reset in ARMED
        do_reset();
        run_to_post(-1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_we", we, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_trig_kept", trig_addr, 3);
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        chk("arm_abort_state", state, 0);
        trig_in = 1'b0;
        start(4'd4);
        chk("rearm_state", state, 1);
        go_to(14);
        chk("rst_armed_pre", state, 2);
        soft_reset = 1'b1;
        arm        = 1'b1;
        sw_trig    = 1'b1;
        tick();
        chk("midrst_state", state, 0);
        chk("midrst_we", we, 0);
        chk("midrst_waddr", waddr, 0);
        chk("midrst_trig_addr", trig_addr, 0);
        chk("midrst_start_addr", start_addr, 0);
        chk("midrst_rd_addr", rd_addr, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        soft_reset = 1'b0;
        arm        = 1'b0;
        sw_trig    = 1'b0;
        tick();
        chk("postrst_state", state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
